// File: rtl/mem_transaction_ctrl.sv
// mem_transaction_ctrl: single-outstanding CPU transaction controller feeding
// memory_interface. Serialises read/write requests onto the TX command and
// payload handshake and reassembles read-data responses from the RX pins.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   req_*                 CPU request channel (valid/ready, we, addr, wdata)
//   rdata, rdata_valid    read result and its one-cycle update pulse
//   unexpected_rx         sticky flag for RX messages that were not expected
//   tx_command_valid,
//   tx_command, tx_data   TX command handshake and LSB-first payload stream
//   tx_command_started,
//   tx_data_next, tx_done TX progress strobes from memory_interface
//   rx_started, rx_data_valid,
//   rx_done, rx_sbs       RX progress strobes from memory_interface
//   rx_pins               raw RX pins (start bits and payload chunks)
module mem_transaction_ctrl #(
    parameter int unsigned IO_BITS        = 2,
    parameter int unsigned TX_CMD_BITS    = 2,
    parameter int unsigned PAYLOAD_CYCLES = 8,
    parameter int unsigned CMD_READ       = 0,
    parameter int unsigned CMD_WADDR      = 1,
    parameter int unsigned CMD_WDATA      = 2,
    parameter int unsigned RX_SB_READ     = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_we,
    input  logic [IO_BITS*PAYLOAD_CYCLES-1:0]     req_addr,
    input  logic [IO_BITS*PAYLOAD_CYCLES-1:0]     req_wdata,
    output logic [IO_BITS*PAYLOAD_CYCLES-1:0]     rdata,
    output logic                                  rdata_valid,
    output logic                                  unexpected_rx,
    output logic                                  tx_command_valid,
    output logic [TX_CMD_BITS-1:0]                tx_command,
    output logic [IO_BITS-1:0]                    tx_data,
    input  logic                                  tx_command_started,
    input  logic                                  tx_data_next,
    input  logic                                  tx_done,
    input  logic                                  rx_data_valid,
    input  logic                                  rx_done,
    input  logic [IO_BITS-1:0]                    rx_sbs,
    input  logic                                  rx_started,
    input  logic [IO_BITS-1:0]                    rx_pins
);

    localparam int unsigned PB = IO_BITS * PAYLOAD_CYCLES;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RADDR   = 3'd1,
        WADDR   = 3'd2,
        WDATA   = 3'd3,
        WAIT_RX = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_sent_q, cmd_sent_d;

    logic [PB-1:0]           addr_q, addr_d;
    logic [PB-1:0]           wdata_q, wdata_d;
    logic [PB-1:0]           shreg_q, shreg_d;
    logic [PB-1:0]           rbuf_q, rbuf_d;
    logic                    armed_q, armed_d;
    logic [PB-1:0]           rdata_q, rdata_d;
    logic                    rdata_valid_q, rdata_valid_d;
    logic                    unexpected_q, unexpected_d;
    logic                    req_ready_q, req_ready_d;
    logic                    tx_cmd_valid_q, tx_cmd_valid_d;
    logic [TX_CMD_BITS-1:0]  tx_command_q, tx_command_d;

    // Start bits are taken from rx_pins at rx_started; rx_sbs is redundant here.
    logic unused_rx_sbs;
    assign unused_rx_sbs = ^rx_sbs;

    // Handshake qualifiers for the current cycle
    logic in_send, accept, start_fire, shift_fire, done_fire, rx_done_fire;
    assign in_send      = (state_q == RADDR) || (state_q == WADDR) || (state_q == WDATA);
    assign accept       = req_valid && req_ready_q;
    assign start_fire   = in_send && !cmd_sent_q && tx_command_started;
    assign shift_fire   = in_send && cmd_sent_q && tx_data_next;
    assign done_fire    = in_send && cmd_sent_q && tx_done;
    assign rx_done_fire = armed_q && !rx_started && rx_done && (state_q == WAIT_RX);

    // State register (FSM state plus per-state cmd_sent flag)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cmd_sent_d = cmd_sent_q;
        unique case (state_q)
            IDLE: begin
                cmd_sent_d = 1'b0;
                if (accept) state_d = req_we ? WADDR : RADDR;
            end
            RADDR, WADDR, WDATA: begin
                if (start_fire) cmd_sent_d = 1'b1;
                if (done_fire) begin
                    cmd_sent_d = 1'b0;
                    case (state_q)
                        RADDR:   state_d = WAIT_RX;
                        WADDR:   state_d = WDATA;
                        default: state_d = IDLE;
                    endcase
                end
            end
            WAIT_RX: begin
                if (rx_done_fire) state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                cmd_sent_d = 1'b0;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        shreg_d       = shreg_q;
        rbuf_d        = rbuf_q;
        armed_d       = armed_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        unexpected_d  = unexpected_q;
        req_ready_d   = (state_d == IDLE);
        tx_cmd_valid_d = 1'b0;
        tx_command_d  = tx_command_q;

        if (accept) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end

        // TX payload: load on command start, then shift out LSB first
        if (start_fire) begin
            shreg_d = (state_q == WDATA) ? wdata_q : addr_q;
        end else if (shift_fire) begin
            shreg_d = {IO_BITS'(0), shreg_q[PB-1:IO_BITS]};
        end

        // RX capture: a new message either arms capture or is flagged
        if (rx_started) begin
            if ((state_q == WAIT_RX) && (rx_pins == IO_BITS'(RX_SB_READ))) begin
                armed_d = 1'b1;
            end else begin
                unexpected_d = 1'b1;
            end
        end else if (armed_q) begin
            if (rx_data_valid) rbuf_d = {rx_pins, rbuf_q[PB-1:IO_BITS]};
            if (rx_done_fire) begin
                rdata_d       = rbuf_d;
                rdata_valid_d = 1'b1;
                armed_d       = 1'b0;
            end
        end

        // Command outputs follow the state being entered so they are registered
        case (state_d)
            RADDR: begin
                tx_cmd_valid_d = !cmd_sent_d;
                tx_command_d   = TX_CMD_BITS'(CMD_READ);
            end
            WADDR: begin
                tx_cmd_valid_d = !cmd_sent_d;
                tx_command_d   = TX_CMD_BITS'(CMD_WADDR);
            end
            WDATA: begin
                tx_cmd_valid_d = !cmd_sent_d;
                tx_command_d   = TX_CMD_BITS'(CMD_WDATA);
            end
            default: tx_cmd_valid_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            shreg_q        <= '0;
            rbuf_q         <= '0;
            armed_q        <= 1'b0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            unexpected_q   <= 1'b0;
            req_ready_q    <= 1'b1;
            tx_cmd_valid_q <= 1'b0;
            tx_command_q   <= TX_CMD_BITS'(CMD_READ);
        end else begin
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            shreg_q        <= shreg_d;
            rbuf_q         <= rbuf_d;
            armed_q        <= armed_d;
            rdata_q        <= rdata_d;
            rdata_valid_q  <= rdata_valid_d;
            unexpected_q   <= unexpected_d;
            req_ready_q    <= req_ready_d;
            tx_cmd_valid_q <= tx_cmd_valid_d;
            tx_command_q   <= tx_command_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign rdata            = rdata_q;
    assign rdata_valid      = rdata_valid_q;
    assign unexpected_rx    = unexpected_q;
    assign tx_command_valid = tx_cmd_valid_q;
    assign tx_command       = tx_command_q;
    assign tx_data          = shreg_q[IO_BITS-1:0];

endmodule

// File: tb/tb_mem_transaction_ctrl.sv
// Directed bench for mem_transaction_ctrl: a table of CPU transactions is
// played against a simple memory_interface model, followed by hand-written
// sequences for back-to-back requests, unexpected RX and mid-transfer reset.
module tb_mem_transaction_ctrl;

    localparam int unsigned PB = 16;
    localparam logic [1:0] C_READ  = 2'd0;
    localparam logic [1:0] C_WADDR = 2'd1;
    localparam logic [1:0] C_WDATA = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [PB-1:0] req_addr, req_wdata, rdata;
    logic          rdata_valid, unexpected_rx;
    logic          tx_command_valid;
    logic [1:0]    tx_command, tx_data;
    logic          tx_command_started, tx_data_next, tx_done;
    logic          rx_data_valid, rx_done, rx_started;
    logic [1:0]    rx_sbs, rx_pins;

    int total = 0;
    int bad   = 0;

    mem_transaction_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .rdata              (rdata),
        .rdata_valid        (rdata_valid),
        .unexpected_rx      (unexpected_rx),
        .tx_command_valid   (tx_command_valid),
        .tx_command         (tx_command),
        .tx_data            (tx_data),
        .tx_command_started (tx_command_started),
        .tx_data_next       (tx_data_next),
        .tx_done            (tx_done),
        .rx_data_valid      (rx_data_valid),
        .rx_done            (rx_done),
        .rx_sbs             (rx_sbs),
        .rx_started         (rx_started),
        .rx_pins            (rx_pins)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          we;
        logic [PB-1:0] addr;
        logic [PB-1:0] wdata;
        logic [PB-1:0] resp;
        int            busy;
        logic [1:0]    exp_cmd;
        logic [PB-1:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_mi();
        tx_command_started = 1'b0;
        tx_data_next       = 1'b0;
        tx_done            = 1'b0;
        rx_data_valid      = 1'b0;
        rx_done            = 1'b0;
        rx_started         = 1'b0;
        rx_sbs             = 2'd0;
        rx_pins            = 2'd0;
    endtask

    task automatic issue(input logic we, input logic [PB-1:0] addr, input logic [PB-1:0] wdata);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
    endtask

    // memory_interface model for one TX message; entered in the cycle after
    // acceptance or after the previous message's tx_done
    task automatic do_tx(input logic [1:0] cmd, input logic [PB-1:0] payload, input int busy);
        logic [PB-1:0] got;
        got = '0;
        check("txv_rise", 32'(tx_command_valid), 32'd1);
        check("tx_cmd", 32'(tx_command), 32'(cmd));
        check("ready_busy", 32'(req_ready), 32'd0);
        for (int i = 0; i < busy; i++) begin
            step();
            check("txv_hold", 32'(tx_command_valid), 32'd1);
            check("tx_cmd_hold", 32'(tx_command), 32'(cmd));
        end
        tx_command_started = 1'b1;
        step();
        tx_command_started = 1'b0;
        check("txv_drop", 32'(tx_command_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tx_data_next = 1'b1;
            got[2*k +: 2] = tx_data;
            step();
        end
        tx_data_next = 1'b0;
        check("tx_payload", 32'(got), 32'(payload));
        tx_done = 1'b1;
        check("tx_cmd_at_done", 32'(tx_command), 32'(cmd));
        step();
        tx_done = 1'b0;
    endtask

    // RX message: start bits, then eight chunks with rx_done on the last one
    task automatic do_rx(input logic [1:0] sb, input logic [PB-1:0] data);
        rx_started = 1'b1;
        rx_pins    = sb;
        rx_sbs     = sb;
        step();
        rx_started = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rx_data_valid = 1'b1;
            rx_pins       = data[2*k +: 2];
            rx_done       = (k == 7);
            step();
        end
        clear_mi();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{we:1'b0, addr:16'h1234, wdata:16'h0000, resp:16'hBEEF, busy:0, exp_cmd:C_READ,  exp_rdata:16'hBEEF};
        vecs[1] = '{we:1'b1, addr:16'h00FF, wdata:16'hA5A5, resp:16'h0000, busy:0, exp_cmd:C_WADDR, exp_rdata:16'hBEEF};
        vecs[2] = '{we:1'b0, addr:16'h8001, wdata:16'h0000, resp:16'h0F0F, busy:5, exp_cmd:C_READ,  exp_rdata:16'h0F0F};
        vecs[3] = '{we:1'b1, addr:16'hFFFF, wdata:16'h0000, resp:16'h0000, busy:2, exp_cmd:C_WADDR, exp_rdata:16'h0F0F};
        vecs[4] = '{we:1'b0, addr:16'hFFFF, wdata:16'h0000, resp:16'hFFFF, busy:1, exp_cmd:C_READ,  exp_rdata:16'hFFFF};
        vecs[5] = '{we:1'b0, addr:16'h0000, wdata:16'h0000, resp:16'h5A3C, busy:0, exp_cmd:C_READ,  exp_rdata:16'h5A3C};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        clear_mi();
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_txv", 32'(tx_command_valid), 32'd0);
        check("rst_txcmd", 32'(tx_command), 32'(C_READ));
        check("rst_txdata", 32'(tx_data), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rdata_valid), 32'd0);
        check("rst_unexp", 32'(unexpected_rx), 32'd0);
        reset = 1'b0;
        step();

        // Table of transactions
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].we, vecs[v].addr, vecs[v].wdata);
            do_tx(vecs[v].exp_cmd, vecs[v].addr, vecs[v].busy);
            if (vecs[v].we) begin
                do_tx(C_WDATA, vecs[v].wdata, 0);
                check("wr_ready_after", 32'(req_ready), 32'd1);
                check("wr_no_rvalid", 32'(rdata_valid), 32'd0);
            end else begin
                check("rd_wait_ready", 32'(req_ready), 32'd0);
                do_rx(2'd1, vecs[v].resp);
                check("rd_rvalid", 32'(rdata_valid), 32'd1);
                check("rd_ready", 32'(req_ready), 32'd1);
            end
            check("rdata", 32'(rdata), 32'(vecs[v].exp_rdata));
            step();
            check("rvalid_pulse", 32'(rdata_valid), 32'd0);
            check("unexp_clean", 32'(unexpected_rx), 32'd0);
        end

        // Request held high during an outstanding read; second one accepted
        // in the cycle rdata_valid appears
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h4321;
        step();
        req_we    = 1'b1;
        req_addr  = 16'h0F00;
        req_wdata = 16'h1357;
        do_tx(C_READ, 16'h4321, 0);
        do_rx(2'd1, 16'h2468);
        check("hold_rvalid", 32'(rdata_valid), 32'd1);
        check("hold_ready", 32'(req_ready), 32'd1);
        check("hold_rdata", 32'(rdata), 32'h2468);
        step();
        req_valid = 1'b0;
        do_tx(C_WADDR, 16'h0F00, 0);
        do_tx(C_WDATA, 16'h1357, 0);
        check("hold_wr_ready", 32'(req_ready), 32'd1);

        // RX message while idle is flagged and ignored
        do_rx(2'd1, 16'hDEAD);
        check("idle_rx_unexp", 32'(unexpected_rx), 32'd1);
        check("idle_rx_rdata", 32'(rdata), 32'h2468);
        check("idle_rx_rvalid", 32'(rdata_valid), 32'd0);

        // Wrong start bits during WAIT_RX, then a good response completes
        issue(1'b0, 16'h0101, 16'h0000);
        do_tx(C_READ, 16'h0101, 0);
        do_rx(2'd2, 16'hCAFE);
        check("badsb_rvalid", 32'(rdata_valid), 32'd0);
        check("badsb_rdata", 32'(rdata), 32'h2468);
        check("badsb_ready", 32'(req_ready), 32'd0);
        do_rx(2'd1, 16'h7E81);
        check("goodsb_rvalid", 32'(rdata_valid), 32'd1);
        check("goodsb_rdata", 32'(rdata), 32'h7E81);
        check("unexp_sticky", 32'(unexpected_rx), 32'd1);
        step();

        // Reset in the middle of the WADDR payload
        issue(1'b1, 16'h3C3C, 16'h9999);
        check("mid_txcmd", 32'(tx_command), 32'(C_WADDR));
        tx_command_started = 1'b1;
        step();
        tx_command_started = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_data_next = 1'b1;
            step();
        end
        tx_data_next = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_txv", 32'(tx_command_valid), 32'd0);
        check("mid_rst_txcmd", 32'(tx_command), 32'(C_READ));
        check("mid_rst_txdata", 32'(tx_data), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_rvalid", 32'(rdata_valid), 32'd0);
        check("mid_rst_unexp", 32'(unexpected_rx), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_txv", 32'(tx_command_valid), 32'd0);
        issue(1'b0, 16'hABCD, 16'h0000);
        do_tx(C_READ, 16'hABCD, 0);
        do_rx(2'd1, 16'h1111);
        check("post_rst_rvalid", 32'(rdata_valid), 32'd1);
        check("post_rst_rdata", 32'(rdata), 32'h1111);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
